// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and default sizes for the shift-add multiplier
package mult_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4
  } state_t;

  // A single-digit display still needs a one-bit pointer.
  function automatic int sel_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - button, datapath status and control pulse bundle for the multiplier controller
interface mult_seq_ctrl_if
  import mult_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
);

  localparam int SEL_W = sel_width(DIGITS);

  logic             start;
  logic             btn_left;
  logic             btn_right;
  logic             z_flag;
  logic             b0;
  logic             load;
  logic             add_en;
  logic             shift;
  logic             busy;
  logic             done;
  logic [SEL_W-1:0] digit_sel;

  modport master (
    input  start, btn_left, btn_right, z_flag, b0,
    output load, add_en, shift, busy, done, digit_sel
  );

  modport slave (
    output start, btn_left, btn_right, z_flag, b0,
    input  load, add_en, shift, busy, done, digit_sel
  );

endinterface

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector whose history resets high so a held level never fires
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic hist;

  always_ff @(posedge clk) begin
    if (reset) hist <= 1'b1;
    else       hist <= level;
  end

  assign rise = level & ~hist;

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - shift-add multiplier sequencer plus display digit pointer
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
)(
  input  logic            clk,
  input  logic            reset,
  mult_seq_ctrl_if.master bus
);

  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam int SEL_W  = sel_width(DIGITS);

  state_t            state;
  state_t            state_next;
  logic [ITER_W-1:0] iter;
  logic              done_q;
  logic [SEL_W-1:0]  digit;
  logic              start_rise;
  logic              left_rise;
  logic              right_rise;
  logic              finish;

  edge_detect u_start (.clk(clk), .reset(reset), .level(bus.start),     .rise(start_rise));
  edge_detect u_left  (.clk(clk), .reset(reset), .level(bus.btn_left),  .rise(left_rise));
  edge_detect u_right (.clk(clk), .reset(reset), .level(bus.btn_right), .rise(right_rise));

  // z_flag and b0 are already valid in TEST: the datapath updated on the edge leaving LOAD/SHIFT.
  assign finish = bus.z_flag || (iter == ITER_W'(WIDTH));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_rise) state_next = LOAD;
      LOAD:    state_next = TEST;
      TEST:    begin
        if (finish)      state_next = IDLE;
        else if (bus.b0) state_next = ADD;
        else             state_next = SHIFT;
      end
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = TEST;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.load   = (state == LOAD);
    bus.add_en = (state == ADD);
    bus.shift  = (state == SHIFT);
    bus.busy   = (state != IDLE);
  end

  // SHIFT is only reachable after a TEST with iter < WIDTH, so iter cannot pass WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter   <= '0;
      done_q <= 1'b0;
    end else begin
      if (state == LOAD)                   iter <= '0;
      else if (state == SHIFT)             iter <= iter + 1'b1;
      if (state == IDLE && start_rise)     done_q <= 1'b0;
      else if (state == TEST && finish)    done_q <= 1'b1;
    end
  end

  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
    end else if (left_rise && !right_rise) begin
      digit <= (digit == SEL_W'(DIGITS - 1)) ? '0 : digit + 1'b1;
    end else if (right_rise && !left_rise) begin
      digit <= (digit == '0) ? SEL_W'(DIGITS - 1) : digit - 1'b1;
    end
  end

  assign bus.digit_sel = digit;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - self-checking bench for mult_seq_ctrl with a datapath stand-in and a behavioural model
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mult_seq_ctrl_if #(.DIGITS(DIGITS_DEF)) bus ();

  mult_seq_ctrl #(.WIDTH(WIDTH_DEF), .DIGITS(DIGITS_DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath stand-in, driven by pulses captured mid-cycle.
  logic [7:0]  op_a = '0, op_b = '0;
  logic [15:0] dp_mc = '0, dp_prod = '0;
  logic [7:0]  dp_mp = '0;
  logic        ld_s = 0, add_s = 0, sh_s = 0;
  int          cnt_load = 0, cnt_add = 0, cnt_shift = 0;

  assign bus.z_flag = (dp_mp == 8'd0);
  assign bus.b0     = dp_mp[0];

  always @(negedge clk) begin
    ld_s  = bus.load;
    add_s = bus.add_en;
    sh_s  = bus.shift;
    if (bus.load)   cnt_load++;
    if (bus.add_en) cnt_add++;
    if (bus.shift)  cnt_shift++;
  end

  always @(posedge clk) begin
    if (ld_s) begin
      dp_mc   <= {8'd0, op_a};
      dp_mp   <= op_b;
      dp_prod <= '0;
    end else begin
      if (add_s) dp_prod <= dp_prod + dp_mc;
      if (sh_s) begin
        dp_mc <= dp_mc << 1;
        dp_mp <= dp_mp >> 1;
      end
    end
  end

  // Model: an accepted start queues the whole pulse schedule ({load,add,shift} per cycle).
  logic [2:0] q[$];
  logic       m_valid = 0, m_done = 0;
  logic       m_prev_s = 1, m_prev_l = 1, m_prev_r = 1;
  int         m_digit = 0;

  always @(posedge clk) begin
    logic [7:0] m;
    logic       l, r;
    if (reset) begin
      q.delete();
      m_done = 0; m_digit = 0; m_valid = 1;
      m_prev_s = 1; m_prev_l = 1; m_prev_r = 1;
    end else begin
      if (q.size() != 0) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1;
      end else if (bus.start && !m_prev_s) begin
        m_done = 0;
        m = op_b;
        q.push_back(3'b100);
        for (int i = 0; i < WIDTH_DEF && m != 0; i++) begin
          q.push_back(3'b000);
          if (m[0]) q.push_back(3'b010);
          q.push_back(3'b001);
          m = m >> 1;
        end
        q.push_back(3'b000);
      end
      l = bus.btn_left && !m_prev_l;
      r = bus.btn_right && !m_prev_r;
      if (l && !r)      m_digit = (m_digit + 1) % DIGITS_DEF;
      else if (r && !l) m_digit = (m_digit + DIGITS_DEF - 1) % DIGITS_DEF;
      m_prev_s = bus.start; m_prev_l = bus.btn_left; m_prev_r = bus.btn_right;
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (m_valid) begin
      e = (q.size() != 0) ? q[0] : 3'b000;
      check("load",      32'(bus.load),      32'(e[2]));
      check("add_en",    32'(bus.add_en),    32'(e[1]));
      check("shift",     32'(bus.shift),     32'(e[0]));
      check("busy",      32'(bus.busy),      32'(q.size() != 0));
      check("done",      32'(bus.done),      32'(m_done));
      check("digit_sel", 32'(bus.digit_sel), 32'(m_digit));
    end
  end

  task automatic start_run(input logic [7:0] a, input logic [7:0] b, output int n);
    @(posedge clk); #1;
    op_a = a; op_b = b;
    cnt_load = 0; cnt_add = 0; cnt_shift = 0;
    bus.start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int exp_delta, input string name);
    bit seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    else       check(name, 32'(cyc - n), 32'(exp_delta));
  endtask

  task automatic press(input logic l, input logic r);
    @(posedge clk); #1;
    bus.btn_left = l; bus.btn_right = r;
    @(posedge clk); #1;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_load",  32'(bus.load),      32'd0);
    check("rst_digit", 32'(bus.digit_sel), 32'd0);

    start_run(8'd5, 8'd0, n);
    wait_done(n, 3, "done_5x0");
    check("loads_5x0",  32'(cnt_load),  32'd1);
    check("adds_5x0",   32'(cnt_add),   32'd0);
    check("shifts_5x0", 32'(cnt_shift), 32'd0);
    check("prod_5x0",   32'(dp_prod),   32'd0);

    press(1'b0, 1'b1);
    check("digit_right_wrap", 32'(bus.digit_sel), 32'd3);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("digit_left_left", 32'(bus.digit_sel), 32'd1);
    press(1'b1, 1'b1);
    check("digit_both", 32'(bus.digit_sel), 32'd1);

    start_run(8'd13, 8'd11, n);
    wait_done(n, 14, "done_13x11");
    check("loads_13x11",  32'(cnt_load),  32'd1);
    check("adds_13x11",   32'(cnt_add),   32'd3);
    check("shifts_13x11", 32'(cnt_shift), 32'd4);
    check("prod_13x11",   32'(dp_prod),   32'd143);

    start_run(8'd13, 8'd11, n);
    @(posedge clk); #1 bus.btn_left = 1'b1;
    @(posedge clk); #1 bus.btn_left = 1'b0;
    wait_done(n, 14, "done_left_busy");
    check("prod_left_busy",  32'(dp_prod),       32'd143);
    check("digit_left_busy", 32'(bus.digit_sel), 32'd2);

    start_run(8'd255, 8'd255, n);
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(n, 27, "done_255x255");
    check("loads_255",  32'(cnt_load),  32'd1);
    check("adds_255",   32'(cnt_add),   32'd8);
    check("shifts_255", 32'(cnt_shift), 32'd8);
    check("prod_255",   32'(dp_prod),   32'd65025);

    start_run(8'd255, 8'd255, n);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(bus.busy),      32'd0);
    check("abort_done",  32'(bus.done),      32'd0);
    check("abort_digit", 32'(bus.digit_sel), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("held_start_busy", 32'(bus.busy), 32'd0);
    end
    @(posedge clk); #1 bus.start = 1'b0;
    start_run(8'd6, 8'd3, n);
    wait_done(n, 9, "done_6x3");
    check("loads_6x3", 32'(cnt_load), 32'd1);
    check("prod_6x3",  32'(dp_prod),  32'd18);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
